// File: rtl/frogger_pkg.sv
// Shared types and constants for the Frogger score readout.
package frogger_pkg;

  // Display controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLASH = 2'd1,
    OVER  = 2'd2
  } disp_state_e;

  // Number of HEX digits driven (index 0 = left player, 1 = right player)
  localparam int NUM_DIG = 2;

  // Active-low segment patterns, bit 0 = segment a
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Game result codes; bit 0 = left, bit 1 = right
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_L    = 2'b01;
  localparam logic [1:0] WIN_R    = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

endpackage

// File: rtl/score_display_if.sv
// Bundle between the score counters / top level and the score readout.
interface score_display_if;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       over_l;
  logic       over_r;
  logic [6:0] hex_l;
  logic [6:0] hex_r;
  logic [1:0] winner;

  // Producer side: score counters feed scores, observe the display
  modport master (
    output score_l, score_r, over_l, over_r,
    input  hex_l, hex_r, winner
  );

  // Display side
  modport slave (
    input  score_l, score_r, over_l, over_r,
    output hex_l, hex_r, winner
  );
endinterface

// File: rtl/seg7_decode.sv
// 4-bit value to active-low 7-segment pattern; 10..15 show blank.
module seg7_decode
  import frogger_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] seg
);

  // Pure lookup; anything outside 0..9 is blanked
  always_comb begin
    seg = SEG_BLANK;
    case (val)
      4'd0: seg = SEG_ZERO;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Two-digit score readout: steady display, flash on score increment,
// continuous blink of the winner's digit once a game is over.
module score_display
  import frogger_pkg::*;
#(
  parameter int BLINK_DIV    = 25_000_000,
  parameter int FLASH_CYCLES = 100_000_000
) (
  input logic            clk,
  input logic            reset,
  score_display_if.slave bus
);

  localparam int FT_W = $clog2(FLASH_CYCLES);
  localparam int BC_W = $clog2(BLINK_DIV);
  localparam logic [FT_W-1:0] FT_LOAD = FT_W'(FLASH_CYCLES - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BLINK_DIV - 1);

  logic [NUM_DIG-1:0][3:0] score, prev;
  logic [NUM_DIG-1:0][6:0] dec, hex_n, hex_q;
  logic [NUM_DIG-1:0]      inc, over, mask, mask_n, blk_n;
  logic [1:0]              win, win_n, over_code;
  disp_state_e             state, state_n;
  logic [FT_W-1:0]         ftmr, ftmr_n;
  logic [BC_W-1:0]         bcnt, bcnt_n;
  logic                    phase, phase_n, blink_clr;
  // Low for the first cycle after reset so a nonzero score present at
  // release is taken as the baseline rather than as an increment.
  logic                    primed;

  assign score = {bus.score_r, bus.score_l};
  assign over  = {bus.over_r, bus.over_l};

  // Per-digit increment detect, decode and blanking
  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    assign inc[i] = primed && (score[i] > prev[i]);
    seg7_decode u_dec (.val(score[i]), .seg(dec[i]));
    assign hex_n[i] = (blk_n[i] && !phase_n) ? SEG_BLANK : dec[i];
  end

  // Map the level over inputs to a result code
  always_comb begin
    over_code = WIN_NONE;
    case (over)
      2'b01:   over_code = WIN_L;
      2'b10:   over_code = WIN_R;
      2'b11:   over_code = WIN_TIE;
      default: over_code = WIN_NONE;
    endcase
  end

  // Next-state logic; over always beats a same-cycle increment
  always_comb begin
    state_n   = state;
    mask_n    = mask;
    win_n     = win;
    ftmr_n    = ftmr;
    blink_clr = 1'b0;
    case (state)
      IDLE: begin
        if (|over) begin
          state_n   = OVER;
          win_n     = over_code;
          blink_clr = 1'b1;
        end else if (|inc) begin
          state_n   = FLASH;
          mask_n    = inc;
          ftmr_n    = FT_LOAD;
          blink_clr = 1'b1;
        end
      end
      FLASH: begin
        if (|over) begin
          state_n   = OVER;
          win_n     = over_code;
          mask_n    = '0;
          blink_clr = 1'b1;
        end else if (|inc) begin
          // retrigger extends the flash but keeps the blink cadence
          mask_n = mask | inc;
          ftmr_n = FT_LOAD;
        end else if (ftmr == '0) begin
          state_n = IDLE;
          mask_n  = '0;
        end else begin
          ftmr_n = ftmr - 1'b1;
        end
      end
      OVER: begin
        // winner stays latched until both over inputs drop
        if (!(|over)) begin
          state_n = IDLE;
          win_n   = WIN_NONE;
        end
      end
      default: begin
        state_n = IDLE;
        mask_n  = '0;
        win_n   = WIN_NONE;
      end
    endcase
  end

  // Blink divider: free-running, restarted in the on phase at FLASH/OVER entry
  always_comb begin
    bcnt_n  = bcnt + 1'b1;
    phase_n = phase;
    if (blink_clr) begin
      bcnt_n  = '0;
      phase_n = 1'b1;
    end else if (bcnt == BC_LAST) begin
      bcnt_n  = '0;
      phase_n = !phase;
    end
  end

  // Which digits blink in the coming cycle
  always_comb begin
    blk_n = '0;
    if (state_n == FLASH)     blk_n = mask_n;
    else if (state_n == OVER) blk_n = win_n;
  end

  // State, history and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      prev   <= '0;
      mask   <= '0;
      win    <= WIN_NONE;
      ftmr   <= '0;
      bcnt   <= '0;
      phase  <= 1'b1;
      primed <= 1'b0;
      hex_q  <= {NUM_DIG{SEG_ZERO}};
    end else begin
      state  <= state_n;
      prev   <= score;
      mask   <= mask_n;
      win    <= win_n;
      ftmr   <= ftmr_n;
      bcnt   <= bcnt_n;
      phase  <= phase_n;
      primed <= 1'b1;
      hex_q  <= hex_n;
    end
  end

  assign bus.hex_l  = hex_q[0];
  assign bus.hex_r  = hex_q[1];
  assign bus.winner = win;

endmodule

// File: tb/tb_score_display.sv
// Scoreboard bench for score_display with a short blink/flash configuration.
module tb_score_display;
  localparam int BD = 4;
  localparam int FC = 16;
  localparam logic [6:0] BLK = 7'b1111111;

  typedef struct {
    string      tag;
    logic [6:0] l;
    logic [6:0] r;
    logic [1:0] w;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t sb[$];

  logic [3:0] cl;
  logic [6:0] el, er;
  logic [1:0] ew;
  logic       ov;

  score_display_if bus();

  score_display #(.BLINK_DIV(BD), .FLASH_CYCLES(FC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // k = cycles since the blink restarted (1 = first output cycle)
  function automatic logic off_ph(input int k);
    return (((k - 1) / BD) % 2) == 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue what the next cycle must show, compare
  task automatic step(input logic [3:0] sl, input logic [3:0] sr,
                      input logic ol, input logic orr,
                      input logic [6:0] xl, input logic [6:0] xr,
                      input logic [1:0] xw, input string tag);
    exp_t e;
    bus.score_l = sl;
    bus.score_r = sr;
    bus.over_l  = ol;
    bus.over_r  = orr;
    e.tag = tag; e.l = xl; e.r = xr; e.w = xw;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    chk({e.tag, " hex_l"},  32'(bus.hex_l),  32'(e.l));
    chk({e.tag, " hex_r"},  32'(bus.hex_r),  32'(e.r));
    chk({e.tag, " winner"}, 32'(bus.winner), 32'(e.w));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.score_l = 4'd5;
    bus.score_r = 4'd0;
    bus.over_l  = 1'b0;
    bus.over_r  = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset hex_l",  32'(bus.hex_l),  32'(7'b1000000));
    chk("reset hex_r",  32'(bus.hex_r),  32'(7'b1000000));
    chk("reset winner", 32'(bus.winner), 32'(2'b00));
    reset = 1'b1;

    // after release the present score shows without a flash
    for (int k = 1; k <= 10; k++)
      step(4'd5, 4'd0, 1'b0, 1'b0, seg_of(4'd5), seg_of(4'd0), 2'b00,
           $sformatf("release k=%0d", k));

    // decrease never flashes
    for (int k = 1; k <= 3; k++)
      step(4'd3, 4'd0, 1'b0, 1'b0, seg_of(4'd3), seg_of(4'd0), 2'b00,
           $sformatf("decrease k=%0d", k));

    // single increment 3->4: blank k=5..8 and 13..16, idle from 17
    for (int k = 1; k <= 22; k++) begin
      el = (k <= 16 && off_ph(k)) ? BLK : seg_of(4'd4);
      step(4'd4, 4'd0, 1'b0, 1'b0, el, seg_of(4'd0), 2'b00,
           $sformatf("single k=%0d", k));
    end

    // retrigger: right increments at k=1, left at k=11, idle from 27
    for (int k = 1; k <= 30; k++) begin
      cl = (k >= 11) ? 4'd5 : 4'd4;
      el = (k >= 11 && k <= 26 && off_ph(k)) ? BLK : seg_of(cl);
      er = (k <= 26 && off_ph(k)) ? BLK : seg_of(4'd1);
      step(cl, 4'd1, 1'b0, 1'b0, el, er, 2'b00, $sformatf("retrig k=%0d", k));
    end

    // tie; leaving OVER with a changed score must not flash
    for (int k = 1; k <= 24; k++) begin
      ov = (k <= 12);
      cl = (k >= 13) ? 4'd6 : 4'd5;
      el = (ov && off_ph(k)) ? BLK : seg_of(cl);
      er = (ov && off_ph(k)) ? BLK : seg_of(4'd1);
      ew = ov ? 2'b11 : 2'b00;
      step(cl, 4'd1, ov, ov, el, er, ew, $sformatf("tie k=%0d", k));
    end

    // increment + over_r together: OVER wins; later over_l keeps winner=10
    for (int k = 1; k <= 16; k++) begin
      ov = (k <= 10);
      er = (ov && off_ph(k)) ? BLK : seg_of(4'd1);
      ew = ov ? 2'b10 : 2'b00;
      step(4'd7, 4'd1, ov && (k >= 5), ov, seg_of(4'd7), er, ew,
           $sformatf("prio k=%0d", k));
    end

    // out-of-range value shows blank
    for (int k = 1; k <= 3; k++)
      step(4'hC, 4'd1, 1'b0, 1'b0, BLK, seg_of(4'd1), 2'b00,
           $sformatf("range k=%0d", k));
    for (int k = 1; k <= 2; k++)
      step(4'd2, 4'd1, 1'b1, 1'b0, seg_of(4'd2), seg_of(4'd1), 2'b01,
           $sformatf("over_l k=%0d", k));

    // asynchronous reset mid-OVER takes effect before the next edge
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async hex_l",  32'(bus.hex_l),  32'(7'b1000000));
    chk("async hex_r",  32'(bus.hex_r),  32'(7'b1000000));
    chk("async winner", 32'(bus.winner), 32'(2'b00));
    @(negedge clk);
    bus.over_l = 1'b0;
    reset = 1'b1;
    for (int k = 1; k <= 8; k++)
      step(4'd2, 4'd1, 1'b0, 1'b0, seg_of(4'd2), seg_of(4'd1), 2'b00,
           $sformatf("post-reset k=%0d", k));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
